// File: rtl/fisc_pkg.sv
// Shared definitions for the FISC memory subsystem: default bus widths and the
// arbiter's state and port-ownership encodings.
package fisc_pkg;

    localparam int FISC_DATA_W = 64;
    localparam int FISC_ADDR_W = 32;
    localparam int LAT_CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        LATENCY = 2'd2,
        RESPOND = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWNER_P0 = 1'b0,
        OWNER_P1 = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/fisc_mem_arbiter.sv
// Two-port round-robin memory arbiter: fetch port p0 (read-only) and load/store
// port p1 share one memory, with exactly one transaction outstanding at a time.
module fisc_mem_arbiter
    import fisc_pkg::*;
#(
    parameter int DATA_W = FISC_DATA_W,
    parameter int ADDR_W = FISC_ADDR_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wait_n,
    input  logic              p0_req,
    input  logic [ADDR_W-1:0] p0_addr,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    input  logic              p1_req,
    input  logic              p1_wr,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_dout,
    input  logic [DATA_W-1:0] mem_din
);

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(RD_LAT - 1);

    arb_state_e           state_q, state_d;
    arb_owner_e           owner_q, owner_d;
    arb_owner_e           last_q, last_d;
    logic                 wr_q, wr_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [DATA_W-1:0]    rsp_q, rsp_d;
    logic [LAT_CNT_W-1:0] cnt_q, cnt_d;

    logic p1_win;
    logic gnt0, gnt1;
    logic rd_stb, wr_stb;
    logic rv0, rv1;

    // p1 wins when alone, or on a tie when p0 was the last port granted.
    assign p1_win = p1_req && (!p0_req || (last_q == OWNER_P0));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            owner_q <= OWNER_P0;
            last_q  <= OWNER_P1;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rsp_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rsp_q   <= rsp_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rsp_d   = rsp_q;
        cnt_d   = cnt_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        rd_stb  = 1'b0;
        wr_stb  = 1'b0;
        rv0     = 1'b0;
        rv1     = 1'b0;

        case (state_q)
            IDLE: begin
                if (wait_n && (p0_req || p1_req)) begin
                    state_d = ACCESS;
                    if (p1_win) begin
                        gnt1    = 1'b1;
                        owner_d = OWNER_P1;
                        last_d  = OWNER_P1;
                        wr_d    = p1_wr;
                        addr_d  = p1_addr;
                        wdata_d = p1_wr ? p1_wdata : '0;
                    end else begin
                        gnt0    = 1'b1;
                        owner_d = OWNER_P0;
                        last_d  = OWNER_P0;
                        wr_d    = 1'b0;
                        addr_d  = p0_addr;
                        wdata_d = '0;
                    end
                end
            end

            ACCESS: begin
                rd_stb = !wr_q;
                wr_stb = wr_q;
                // The strobe cycle itself is the first of the RD_LAT read cycles.
                if (wait_n) begin
                    if (wr_q) begin
                        state_d = RESPOND;
                    end else if (LAT_LOAD == '0) begin
                        rsp_d   = mem_din;
                        state_d = RESPOND;
                    end else begin
                        cnt_d   = LAT_LOAD;
                        state_d = LATENCY;
                    end
                end
            end

            LATENCY: begin
                if (wait_n) begin
                    if (cnt_q == LAT_CNT_W'(1)) begin
                        rsp_d   = mem_din;
                        cnt_d   = '0;
                        state_d = RESPOND;
                    end else begin
                        cnt_d = cnt_q - LAT_CNT_W'(1);
                    end
                end
            end

            RESPOND: begin
                rv0     = (owner_q == OWNER_P0);
                rv1     = (owner_q == OWNER_P1);
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Grants are combinational from the requests, so mask them while reset is held.
    assign p0_gnt    = gnt0 & reset_n;
    assign p1_gnt    = gnt1 & reset_n;
    assign p0_rvalid = rv0;
    assign p1_rvalid = rv1;
    assign mem_rd    = rd_stb;
    assign mem_wr    = wr_stb;
    assign mem_addr  = addr_q;
    assign mem_dout  = wdata_q;
    assign rsp_data  = rsp_q;

endmodule

// File: tb/tb_fisc_mem_arbiter.sv
// Self-checking bench for fisc_mem_arbiter: directed scenarios plus randomized
// traffic against a transaction-level reference model, for RD_LAT of 1 and 3.
module tb_fisc_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wait_n = 1'b1;
    logic        sel = 1'b0;
    logic        p0_req = 1'b0;
    logic [31:0] p0_addr = '0;
    logic        p1_req = 1'b0;
    logic        p1_wr = 1'b0;
    logic [31:0] p1_addr = '0;
    logic [63:0] p1_wdata = '0;
    logic [63:0] mem_din = '0;

    logic [1:0]  o_p0_gnt, o_p0_rvalid, o_p1_gnt, o_p1_rvalid, o_mem_rd, o_mem_wr;
    logic [63:0] o_rsp_data [2];
    logic [31:0] o_mem_addr [2];
    logic [63:0] o_mem_dout [2];

    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, mem_rd, mem_wr;
    logic [63:0] rsp_data, mem_dout;
    logic [31:0] mem_addr;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // Instance 0 has RD_LAT=1, instance 1 has RD_LAT=3; sel picks the active one.
    fisc_mem_arbiter #(.DATA_W(64), .ADDR_W(32), .RD_LAT(1)) dut_lat1 (
        .clk(clk), .reset_n(reset_n), .wait_n(wait_n),
        .p0_req(p0_req & ~sel), .p0_addr(p0_addr),
        .p0_gnt(o_p0_gnt[0]), .p0_rvalid(o_p0_rvalid[0]),
        .p1_req(p1_req & ~sel), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(o_p1_gnt[0]), .p1_rvalid(o_p1_rvalid[0]),
        .rsp_data(o_rsp_data[0]), .mem_rd(o_mem_rd[0]), .mem_wr(o_mem_wr[0]),
        .mem_addr(o_mem_addr[0]), .mem_dout(o_mem_dout[0]), .mem_din(mem_din)
    );

    fisc_mem_arbiter #(.DATA_W(64), .ADDR_W(32), .RD_LAT(3)) dut_lat3 (
        .clk(clk), .reset_n(reset_n), .wait_n(wait_n),
        .p0_req(p0_req & sel), .p0_addr(p0_addr),
        .p0_gnt(o_p0_gnt[1]), .p0_rvalid(o_p0_rvalid[1]),
        .p1_req(p1_req & sel), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(o_p1_gnt[1]), .p1_rvalid(o_p1_rvalid[1]),
        .rsp_data(o_rsp_data[1]), .mem_rd(o_mem_rd[1]), .mem_wr(o_mem_wr[1]),
        .mem_addr(o_mem_addr[1]), .mem_dout(o_mem_dout[1]), .mem_din(mem_din)
    );

    assign p0_gnt    = o_p0_gnt[sel];
    assign p0_rvalid = o_p0_rvalid[sel];
    assign p1_gnt    = o_p1_gnt[sel];
    assign p1_rvalid = o_p1_rvalid[sel];
    assign mem_rd    = o_mem_rd[sel];
    assign mem_wr    = o_mem_wr[sel];
    assign rsp_data  = o_rsp_data[sel];
    assign mem_addr  = o_mem_addr[sel];
    assign mem_dout  = o_mem_dout[sel];

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        return {~a, a};
    endfunction

    // Tasks start and end just after a falling edge.
    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        p0_req  = 1'b0;
        p1_req  = 1'b0;
        p1_wr   = 1'b0;
        wait_n  = 1'b1;
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        p0_req  = 1'b1;
        p1_req  = 1'b1;
        wait_n  = 1'b1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            total++;
            if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_rd, mem_wr} !== 6'b0) begin
                bad++;
                $display("[TB] FAIL reset_ctrl inst=%0d got=%b want=000000", s,
                         {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_rd, mem_wr});
            end
            total++;
            if (mem_addr !== 32'h0 || mem_dout !== 64'h0 || rsp_data !== 64'h0) begin
                bad++;
                $display("[TB] FAIL reset_data inst=%0d got addr=%h dout=%h rsp=%h want all 0",
                         s, mem_addr, mem_dout, rsp_data);
            end
        end
        sel    = 1'b0;
        p0_req = 1'b0;
        p1_req = 1'b0;
        next_cycle();
        reset_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_round_robin();
        int waited;
        sel      = 1'b0;
        wait_n   = 1'b1;
        p0_req   = 1'b1;
        p0_addr  = 32'h1;
        p1_req   = 1'b1;
        p1_wr    = 1'b1;
        p1_addr  = 32'h2;
        p1_wdata = 64'h3;
        for (int k = 0; k < 4; k++) begin
            waited = 0;
            #1;
            while (!(p0_gnt || p1_gnt) && waited < 10) begin
                next_cycle();
                #1;
                waited++;
            end
            total++;
            if (waited >= 10) begin
                bad++;
                $display("[TB] FAIL rr_timeout grant=%0d got no grant want a grant", k);
            end else if ({p0_gnt, p1_gnt} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                bad++;
                $display("[TB] FAIL rr_order grant=%0d got {p0,p1}=%b want %b", k,
                         {p0_gnt, p1_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
            end
            next_cycle();
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        for (int i = 0; i < 3; i++) next_cycle();
    endtask

    task automatic test_single_read();
        sel     = 1'b0;
        wait_n  = 1'b1;
        p0_req  = 1'b1;
        p0_addr = 32'h10;
        mem_din = 64'hDEAD;
        #1;
        total++;
        if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rd_gnt got {p0,p1}=%b want 10", {p0_gnt, p1_gnt});
        end
        next_cycle();
        p0_req  = 1'b0;
        p0_addr = 32'h99;
        mem_din = 64'hAA;
        #1;
        total++;
        if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 32'h10) begin
            bad++;
            $display("[TB] FAIL rd_strobe got rd=%b wr=%b addr=%h want 1 0 10", mem_rd, mem_wr, mem_addr);
        end
        total++;
        if (p0_rvalid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rd_early got rvalid=%b want 0", p0_rvalid);
        end
        next_cycle();
        mem_din = 64'hBAD;
        #1;
        total++;
        if (p0_rvalid !== 1'b1 || p1_rvalid !== 1'b0 || mem_rd !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rd_rvalid got p0=%b p1=%b rd=%b want 1 0 0", p0_rvalid, p1_rvalid, mem_rd);
        end
        total++;
        if (rsp_data !== 64'hAA) begin
            bad++;
            $display("[TB] FAIL rd_data got %h want aa", rsp_data);
        end
        next_cycle();
        #1;
        total++;
        if (p0_rvalid !== 1'b0 || rsp_data !== 64'hAA) begin
            bad++;
            $display("[TB] FAIL rd_hold got rvalid=%b rsp=%h want 0 aa", p0_rvalid, rsp_data);
        end
        next_cycle();
    endtask

    task automatic test_write();
        sel      = 1'b0;
        wait_n   = 1'b1;
        p1_req   = 1'b1;
        p1_wr    = 1'b1;
        p1_addr  = 32'h20;
        p1_wdata = 64'h55;
        #1;
        total++;
        if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0) begin
            bad++;
            $display("[TB] FAIL wr_gnt got {p0,p1}=%b want 01", {p0_gnt, p1_gnt});
        end
        next_cycle();
        p1_req   = 1'b0;
        p1_wr    = 1'b0;
        p1_addr  = 32'hFFFF;
        p1_wdata = 64'h1234;
        #1;
        total++;
        if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 32'h20 || mem_dout !== 64'h55) begin
            bad++;
            $display("[TB] FAIL wr_strobe got wr=%b rd=%b addr=%h dout=%h want 1 0 20 55",
                     mem_wr, mem_rd, mem_addr, mem_dout);
        end
        next_cycle();
        #1;
        total++;
        if (p1_rvalid !== 1'b1 || p0_rvalid !== 1'b0 || mem_wr !== 1'b0) begin
            bad++;
            $display("[TB] FAIL wr_done got p1=%b p0=%b wr=%b want 1 0 0", p1_rvalid, p0_rvalid, mem_wr);
        end
        next_cycle();
        #1;
        total++;
        if (p1_rvalid !== 1'b0 || mem_wr !== 1'b0) begin
            bad++;
            $display("[TB] FAIL wr_end got rvalid=%b wr=%b want 0 0", p1_rvalid, mem_wr);
        end
        next_cycle();
    endtask

    task automatic test_wait_stall();
        sel     = 1'b1;
        wait_n  = 1'b1;
        p0_req  = 1'b1;
        p0_addr = 32'h30;
        mem_din = '1;
        #1;
        total++;
        if (p0_gnt !== 1'b1) begin
            bad++;
            $display("[TB] FAIL st_gnt got %b want 1", p0_gnt);
        end
        // Cycles 1-3 stalled, 4 releases the strobe, 5-6 latency, 7 responds.
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            p0_req  = 1'b0;
            wait_n  = (c >= 4);
            mem_din = (c == 6) ? 64'h77 : (64'hF0F0_0000 ^ 64'(c));
            #1;
            total++;
            if (mem_rd !== (c <= 4) || p0_gnt !== 1'b0) begin
                bad++;
                $display("[TB] FAIL st_strobe cyc=%0d got rd=%b gnt=%b want %b 0", c, mem_rd, p0_gnt, c <= 4);
            end
            total++;
            if (p0_rvalid !== (c == 7)) begin
                bad++;
                $display("[TB] FAIL st_rvalid cyc=%0d got %b want %b", c, p0_rvalid, c == 7);
            end
            if (c == 7) begin
                total++;
                if (rsp_data !== 64'h77) begin
                    bad++;
                    $display("[TB] FAIL st_data got %h want 77", rsp_data);
                end
            end
        end
    endtask

    task automatic test_reset_latency();
        sel     = 1'b1;
        wait_n  = 1'b1;
        p0_req  = 1'b1;
        p0_addr = 32'h44;
        mem_din = 64'h1111;
        next_cycle();
        p0_req = 1'b0;
        next_cycle();
        reset_n = 1'b0;
        #1;
        total++;
        if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_rd, mem_wr} !== 6'b0 ||
            mem_addr !== 32'h0 || rsp_data !== 64'h0 || mem_dout !== 64'h0) begin
            bad++;
            $display("[TB] FAIL rst_mid got ctrl=%b addr=%h rsp=%h want all 0",
                     {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_rd, mem_wr}, mem_addr, rsp_data);
        end
        next_cycle();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0 || mem_rd !== 1'b0) begin
                bad++;
                $display("[TB] FAIL rst_norv cyc=%0d got rv0=%b rv1=%b rd=%b want 0 0 0",
                         i, p0_rvalid, p1_rvalid, mem_rd);
            end
            next_cycle();
        end
        p1_req  = 1'b1;
        p1_wr   = 1'b0;
        p1_addr = 32'h50;
        #1;
        total++;
        if (p1_gnt !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rst_regnt got %b want 1", p1_gnt);
        end
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            p1_req  = 1'b0;
            mem_din = (c == 3) ? 64'h5A5A : 64'h0BAD;
            #1;
            total++;
            if (p1_rvalid !== (c == 4) || mem_rd !== (c == 1)) begin
                bad++;
                $display("[TB] FAIL rst_serve cyc=%0d got rv=%b rd=%b want %b %b",
                         c, p1_rvalid, mem_rd, c == 4, c == 1);
            end
        end
        total++;
        if (rsp_data !== 64'h5A5A) begin
            bad++;
            $display("[TB] FAIL rst_data got %h want 5a5a", rsp_data);
        end
        next_cycle();
    endtask

    // Transaction-level model: a grant opens a transaction that strobes until the
    // first wait_n=1 cycle and responds after wr?1:RD_LAT wait_n=1 cycles.
    task automatic test_random(input int cycles, input int lat);
        bit          busy = 0, resp = 0, strobe_done = 0, m_wr = 0, m_p1 = 0, last_p1 = 1;
        bit          idle, exp_g0, exp_g1, exp_rd, exp_wr, sample_now;
        int          ones_left = 0;
        logic [31:0] m_addr = '0;
        logic [63:0] m_data = '0, last_rsp = '0;
        sel = (lat == 3);
        do_reset();
        for (int n = 0; n < cycles; n++) begin
            wait_n = ($urandom_range(0, 3) != 0);
            if (!p0_req && $urandom_range(0, 2) == 0) begin
                p0_req  = 1'b1;
                p0_addr = $urandom;
            end
            if (!p1_req && $urandom_range(0, 2) == 0) begin
                p1_req   = 1'b1;
                p1_wr    = 1'($urandom_range(0, 1));
                p1_addr  = $urandom;
                p1_wdata = {$urandom, $urandom};
            end
            sample_now = busy && !m_wr && wait_n && (ones_left == 1);
            mem_din = sample_now ? mem_word(m_addr) : {$urandom, $urandom};
            #1;
            idle   = !busy && !resp;
            exp_g0 = idle && wait_n && p0_req && (!p1_req || last_p1);
            exp_g1 = idle && wait_n && p1_req && (!p0_req || !last_p1);
            exp_rd = busy && !strobe_done && !m_wr;
            exp_wr = busy && !strobe_done && m_wr;
            total++;
            if ({p0_gnt, p1_gnt} !== {exp_g0, exp_g1}) begin
                bad++;
                $display("[TB] FAIL rnd_gnt lat=%0d n=%0d got %b want %b", lat, n, {p0_gnt, p1_gnt}, {exp_g0, exp_g1});
            end
            total++;
            if ({mem_rd, mem_wr} !== {exp_rd, exp_wr}) begin
                bad++;
                $display("[TB] FAIL rnd_strobe lat=%0d n=%0d got %b want %b", lat, n, {mem_rd, mem_wr}, {exp_rd, exp_wr});
            end
            if (exp_rd || exp_wr) begin
                total++;
                if (mem_addr !== m_addr || (exp_wr && mem_dout !== m_data)) begin
                    bad++;
                    $display("[TB] FAIL rnd_mem lat=%0d n=%0d got addr=%h dout=%h want %h %h",
                             lat, n, mem_addr, mem_dout, m_addr, m_data);
                end
            end
            total++;
            if ({p0_rvalid, p1_rvalid} !== {resp && !m_p1, resp && m_p1}) begin
                bad++;
                $display("[TB] FAIL rnd_rvalid lat=%0d n=%0d got %b want %b", lat, n,
                         {p0_rvalid, p1_rvalid}, {resp && !m_p1, resp && m_p1});
            end
            total++;
            if (rsp_data !== last_rsp) begin
                bad++;
                $display("[TB] FAIL rnd_rsp lat=%0d n=%0d got %h want %h", lat, n, rsp_data, last_rsp);
            end
            total++;
            if (mem_rd === 1'b1 && mem_wr === 1'b1) begin
                bad++;
                $display("[TB] FAIL rnd_excl lat=%0d n=%0d got rd=1 wr=1 want not both", lat, n);
            end
            if (exp_g0 || exp_g1) begin
                busy        = 1;
                strobe_done = 0;
                m_p1        = exp_g1;
                m_wr        = exp_g1 && p1_wr;
                m_addr      = exp_g1 ? p1_addr : p0_addr;
                m_data      = (exp_g1 && p1_wr) ? p1_wdata : 64'h0;
                ones_left   = m_wr ? 1 : lat;
                last_p1     = exp_g1;
            end else if (busy) begin
                if (wait_n) begin
                    strobe_done = 1;
                    ones_left--;
                    if (sample_now) last_rsp = mem_din;
                    if (ones_left == 0) begin
                        busy = 0;
                        resp = 1;
                    end
                end
            end else if (resp) begin
                resp = 0;
            end
            next_cycle();
            if (exp_g0) p0_req = 1'b0;
            if (exp_g1) begin
                p1_req   = 1'b0;
                p1_addr  = $urandom;
                p1_wdata = {$urandom, $urandom};
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        wait_n = 1'b1;
        for (int i = 0; i < 6; i++) next_cycle();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog got no finish want finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_single_read();
        test_write();
        test_wait_stall();
        test_reset_latency();
        test_random(800, 1);
        test_random(800, 3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fisc_mem_arbiter.md
FISC_MEM_ARBITER -- requirements
Module: fisc_mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 64, memory word width.
REQ-002 SHALL have parameter ADDR_W, default 32, memory word-address width.
REQ-003 SHALL have parameter RD_LAT, default 1, read latency in cycles from strobe to data (legal 1..15).
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port wait_n  in  1  0 = stall: no new grant, strobes held, latency counter frozen.
REQ-007 SHALL have port p0_req  in  1  fetch-port read request, held until p0_gnt.
REQ-008 SHALL have port p0_addr  in  ADDR_W  fetch-port address.
REQ-009 SHALL have port p0_gnt  out  1  one-cycle pulse, p0 request accepted.
REQ-010 SHALL have port p0_rvalid  out  1  one-cycle pulse, rsp_data valid for p0.
REQ-011 SHALL have port p1_req  in  1  load/store request, held until p1_gnt.
REQ-012 SHALL have port p1_wr  in  1  1 = write, 0 = read.
REQ-013 SHALL have port p1_addr  in  ADDR_W  load/store address.
REQ-014 SHALL have port p1_wdata  in  DATA_W  write data.
REQ-015 SHALL have port p1_gnt  out  1  one-cycle pulse, p1 request accepted.
REQ-016 SHALL have port p1_rvalid  out  1  one-cycle pulse, read data valid, or write-done when p1_wr was 1.
REQ-017 SHALL have port rsp_data  out  DATA_W  shared read-response data.
REQ-018 SHALL have port mem_rd  out  1  memory read strobe.
REQ-019 SHALL have port mem_wr  out  1  memory write strobe.
REQ-020 SHALL have port mem_addr  out  ADDR_W  memory address.
REQ-021 SHALL have port mem_dout  out  DATA_W  memory write data.
REQ-022 SHALL have port mem_din  in  DATA_W  memory read data, sampled RD_LAT cycles after strobe.

Function
REQ-023 SHALL implement FSM states IDLE, ACCESS, LATENCY, RESPOND.
REQ-024 SHALL, in IDLE with wait_n=1 and any req, assert the winner's gnt that cycle, latch addr/wr/wdata/owner, and go to ACCESS next cycle.
REQ-025 SHALL arbitrate round-robin: on simultaneous p0_req and p1_req, the port not granted last wins; a lone requester always wins.
REQ-026 SHALL drive mem_rd or mem_wr high with latched mem_addr/mem_dout for exactly one ACCESS cycle when wait_n=1, extending ACCESS while wait_n=0.
REQ-027 SHALL, on a write, go from ACCESS to RESPOND.
REQ-028 SHALL, on a read, go from ACCESS to LATENCY, counting RD_LAT-1 further wait_n=1 cycles (zero when RD_LAT=1), then sample mem_din into rsp_data and go to RESPOND.
REQ-029 SHALL, in RESPOND, pulse the owner's rvalid for one cycle with rsp_data stable, then return to IDLE.
REQ-030 SHALL leave only one transaction outstanding; a grant never occurs outside IDLE.
REQ-031 SHALL not grant p0 when p0 is idle; p1 write address/data are taken only at grant, later input changes ignored.
REQ-032 SHALL update the round-robin pointer only on a grant.
REQ-033 SHALL keep rsp_data holding its last value outside RESPOND; mem_rd and mem_wr are never both 1.

Reset
REQ-034 SHALL, on reset_n=0 at any time, drive all gnt, rvalid and strobes to 0, mem_addr/mem_dout/rsp_data to 0, FSM to IDLE, pointer to favour p0, and discard any in-flight transaction with no rvalid.
REQ-035 SHALL deassert reset without glitches; the first grant occurs no earlier than the first edge after reset_n=1.

Structure
REQ-036 SHALL take DATA_W/ADDR_W defaults and the state enum from shared package fisc_pkg.
REQ-037 SHALL be a single module with no sub-modules; the latency counter is 4 bits.

Verification
REQ-038 SHALL cover: p0 read 0x10 alone, RD_LAT=1, mem_din=0xAA -> gnt at T0, mem_rd at T1, p0_rvalid at T2 with rsp_data=0xAA.
REQ-039 SHALL cover: p0 and p1 request together after reset -> p0 granted first, then p1, alternating while both held.
REQ-040 SHALL cover: p1 write 0x20/0x55 -> mem_wr one cycle with mem_addr=0x20, mem_dout=0x55, p1_rvalid next cycle.
REQ-041 SHALL cover: wait_n=0 for 3 cycles during ACCESS, RD_LAT=3 -> strobe held 4 cycles, rvalid 3 cycles after strobe release.
REQ-042 SHALL cover: reset_n pulsed low in LATENCY -> outputs 0 immediately, no rvalid, next request served normally.
